// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, oversampled 3-tap majority vote,
// parity/framing/overrun/break detection, valid/ready holding register on the output.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int TICK_RAW = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int CNT_W    = 4;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_SAMP_A = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_SAMP_B = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_DECIDE = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    logic expected;
    expected = (PARITY == 1) ? ~(^d) : (^d);
    return (PARITY != 0) && (p != expected);
  endfunction

  state_t               state;
  logic                 rx_p0, rx_p1, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 tick, samp_lo, samp_mid, decide, bit_end, vote, last_stop;
  logic                 samp_a, samp_b, par_bit, zero_acc, fe_acc;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] word_p0;
  logic                 perr_p0, ferr_p0, done_p0;

  // Stage: input synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end
  assign rx_s = rx_p1;

  assign tick      = (div_cnt == DIV_LAST);
  assign samp_lo   = tick && (os_cnt == OS_SAMP_A);
  assign samp_mid  = tick && (os_cnt == OS_SAMP_B);
  assign decide    = tick && (os_cnt == OS_DECIDE);
  assign bit_end   = tick && (os_cnt == OS_LAST);
  assign vote      = majority3(samp_a, samp_b, rx_s);
  assign last_stop = (state == S_STOP) && decide && (bit_cnt == STOP_LAST);

  // Stage: control FSM, tick divider and bit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      done_p0   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      done_p0   <= 1'b0;
      break_det <= 1'b0;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      if (tick) os_cnt <= os_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            div_cnt <= '0;
            os_cnt  <= '0;
          end
        end
        S_START: begin
          if (decide && vote) begin
            state <= S_IDLE;
          end else if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state   <= S_STOP;
            bit_cnt <= '0;
          end
        end
        S_STOP: begin
          // Completing at the decision tick leaves half a stop bit to catch the next start edge
          if (last_stop) begin
            if (zero_acc && !vote) begin
              break_det <= 1'b1;
              state     <= S_BRK_WAIT;
            end else begin
              done_p0 <= 1'b1;
              state   <= S_IDLE;
            end
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_BRK_WAIT: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage: sample capture and frame assembly
  always_ff @(posedge clk) begin
    if (samp_lo)  samp_a <= rx_s;
    if (samp_mid) samp_b <= rx_s;
    if ((state == S_START) && bit_end) begin
      zero_acc <= 1'b1;
      fe_acc   <= 1'b0;
    end
    if (decide) begin
      case (state)
        S_DATA: begin
          shreg    <= {vote, shreg[DATA_BITS-1:1]};
          zero_acc <= zero_acc & ~vote;
        end
        S_PARITY: begin
          par_bit  <= vote;
          zero_acc <= zero_acc & ~vote;
        end
        S_STOP: begin
          fe_acc   <= fe_acc | ~vote;
          zero_acc <= zero_acc & ~vote;
        end
        default: ;
      endcase
    end
    if (last_stop) begin
      word_p0 <= shreg;
      perr_p0 <= parity_mismatch(shreg, par_bit);
      ferr_p0 <= fe_acc | ~vote;
    end
  end

  // Stage: holding register and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (done_p0) begin
        if (!data_valid || data_ready) begin
          data_out   <= word_p0;
          parity_err <= perr_p0;
          frame_err  <= ferr_p0;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receivers (8N1, 7E1, 8N2) share one serial line.
module tb_uart_rx_cfg;

  localparam int BIT = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic data_ready = 1'b1;

  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic dv0, pe0, fe0, ov0, bk0;
  logic dv1, pe1, fe1, ov1, bk1;
  logic dv2, pe2, fe2, ov2, bk2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int acc0 = 0, acc1 = 0, acc2 = 0, hi0 = 0;
  int novr0 = 0, nbrk0 = 0, nbrk1 = 0, nbrk2 = 0;
  int wcyc0 = 0;
  logic [7:0] w0 = '0, w2 = '0;
  logic [6:0] w1 = '0;
  logic wpe0 = 1'b0, wfe0 = 1'b0, wpe1 = 1'b0, wfe1 = 1'b0, wpe2 = 1'b0, wfe2 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(48000000), .BAUDRATE(1000000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(d0), .data_valid(dv0),
    .data_ready(data_ready), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .break_det(bk0));

  uart_rx_cfg #(.CLK_FREQ(48000000), .BAUDRATE(1000000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(1), .OVERSAMPLE(16)) u_7e1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(d1), .data_valid(dv1),
    .data_ready(data_ready), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .break_det(bk1));

  uart_rx_cfg #(.CLK_FREQ(48000000), .BAUDRATE(1000000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(2), .OVERSAMPLE(16)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(d2), .data_valid(dv2),
    .data_ready(data_ready), .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .break_det(bk2));

  always @(posedge clk) cyc <= cyc + 1;

  // Records every accepted word and every pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (dv0) hi0 <= hi0 + 1;
    if (dv0 && data_ready) begin
      acc0 <= acc0 + 1; w0 <= d0; wpe0 <= pe0; wfe0 <= fe0; wcyc0 <= cyc;
    end
    if (dv1 && data_ready) begin
      acc1 <= acc1 + 1; w1 <= d1; wpe1 <= pe1; wfe1 <= fe1;
    end
    if (dv2 && data_ready) begin
      acc2 <= acc2 + 1; w2 <= d2; wpe2 <= pe2; wfe2 <= fe2;
    end
    if (ov0) novr0 <= novr0 + 1;
    if (bk0) nbrk0 <= nbrk0 + 1;
    if (bk1) nbrk1 <= nbrk1 + 1;
    if (bk2) nbrk2 <= nbrk2 + 1;
  end

  // Drives n bits LSB first; glitch flips one clock inside each data bit near its centre
  task automatic send_bits(input logic [15:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < BIT; c++) begin
        @(negedge clk);
        rx = bits[i];
        if (glitch && i >= 1 && i <= 8 && c == 23 + i) rx = ~bits[i];
      end
    end
  endtask

  task automatic idle_bits(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_8n1(input logic [7:0] b);
    send_bits({6'h3f, 1'b1, b, 1'b0}, 10, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({dv0, pe0, fe0, ov0, bk0, d0} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_8n1: got %h, expected 0", {dv0, pe0, fe0, ov0, bk0, d0});
    end
    n_chk++;
    if ({dv1, dv2, bk1, bk2, ov1, ov2, d1, d2} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_others: got %h, expected 0", {dv1, dv2, bk1, bk2, ov1, ov2, d1, d2});
    end
    rst_n = 1'b1;
    idle_bits(2);
  endtask

  task automatic test_8n1;
    int a, h, t;
    a = acc0; h = hi0; t = cyc;
    send_8n1(8'hA5);
    idle_bits(2);
    n_chk++;
    if (acc0 - a !== 1) begin
      n_fail++; $display("FAIL 8n1_count: got %0d words, expected 1", acc0 - a);
    end
    n_chk++;
    if (hi0 - h !== 1) begin
      n_fail++; $display("FAIL 8n1_valid_len: got %0d cycles, expected 1", hi0 - h);
    end
    n_chk++;
    if (w0 !== 8'hA5) begin
      n_fail++; $display("FAIL 8n1_data: got %h, expected a5", w0);
    end
    n_chk++;
    if ({wpe0, wfe0} !== 2'b00) begin
      n_fail++; $display("FAIL 8n1_flags: got %b, expected 00", {wpe0, wfe0});
    end
    n_chk++;
    if (wcyc0 - t < 9 * BIT || wcyc0 - t > 10 * BIT) begin
      n_fail++; $display("FAIL 8n1_latency: got %0d clocks, expected %0d..%0d", wcyc0 - t, 9 * BIT, 10 * BIT);
    end
  endtask

  // 0x35 has four ones, so even parity wants a 0 parity bit
  task automatic test_parity;
    logic [1:0] pbits;
    logic [1:0] exp_pe;
    int a;
    pbits = 2'b10;
    exp_pe = 2'b10;
    for (int k = 0; k < 2; k++) begin
      a = acc1;
      send_bits({6'h3f, 1'b1, pbits[k], 7'h35, 1'b0}, 10, 1'b0);
      idle_bits(3);
      n_chk++;
      if (acc1 - a !== 1) begin
        n_fail++; $display("FAIL parity_count[%0d]: got %0d words, expected 1", k, acc1 - a);
      end
      n_chk++;
      if (w1 !== 7'h35) begin
        n_fail++; $display("FAIL parity_data[%0d]: got %h, expected 35", k, w1);
      end
      n_chk++;
      if ({wpe1, wfe1} !== {exp_pe[k], 1'b0}) begin
        n_fail++; $display("FAIL parity_flags[%0d]: got %b, expected %b", k, {wpe1, wfe1}, {exp_pe[k], 1'b0});
      end
    end
  endtask

  task automatic test_stop_bits;
    int a;
    a = acc2;
    send_bits({5'h1f, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, 1'b0);
    idle_bits(12);
    n_chk++;
    if (acc2 - a !== 1) begin
      n_fail++; $display("FAIL stop2_count: got %0d words, expected 1", acc2 - a);
    end
    n_chk++;
    if (w2 !== 8'h3C) begin
      n_fail++; $display("FAIL stop2_data: got %h, expected 3c", w2);
    end
    n_chk++;
    if ({wpe2, wfe2} !== 2'b01) begin
      n_fail++; $display("FAIL stop2_flags: got %b, expected 01", {wpe2, wfe2});
    end
  endtask

  task automatic test_glitch;
    int a;
    a = acc0;
    send_bits({6'h3f, 1'b1, 8'hA5, 1'b0}, 10, 1'b1);
    idle_bits(3);
    n_chk++;
    if (acc0 - a !== 1 || w0 !== 8'hA5) begin
      n_fail++; $display("FAIL glitch_8n1: got %0d words data %h, expected 1 words data a5", acc0 - a, w0);
    end
    n_chk++;
    if (w2 !== 8'hA5) begin
      n_fail++; $display("FAIL glitch_8n2: got %h, expected a5", w2);
    end
  endtask

  task automatic test_back_to_back;
    int o;
    o = novr0;
    data_ready = 1'b0;
    send_8n1(8'h11);
    send_8n1(8'h22);
    idle_bits(2);
    n_chk++;
    if ({dv0, d0} !== {1'b1, 8'h11}) begin
      n_fail++; $display("FAIL overrun_hold: got valid %b data %h, expected 1 11", dv0, d0);
    end
    n_chk++;
    if (novr0 - o !== 1) begin
      n_fail++; $display("FAIL overrun_pulses: got %0d, expected 1", novr0 - o);
    end
    @(posedge clk);
    #1 data_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (dv0 !== 1'b0) begin
      n_fail++; $display("FAIL overrun_release: got valid %b, expected 0", dv0);
    end
    n_chk++;
    if (w0 !== 8'h11) begin
      n_fail++; $display("FAIL overrun_accepted: got %h, expected 11", w0);
    end
    idle_bits(3);
  endtask

  task automatic test_break;
    int a, b0, b1, b2;
    a = acc0; b0 = nbrk0; b1 = nbrk1; b2 = nbrk2;
    send_bits(16'h0000, 12, 1'b0);
    idle_bits(3);
    n_chk++;
    if (nbrk0 - b0 !== 1) begin
      n_fail++; $display("FAIL break_8n1: got %0d pulses, expected 1", nbrk0 - b0);
    end
    n_chk++;
    if (acc0 - a !== 0) begin
      n_fail++; $display("FAIL break_no_word: got %0d words, expected 0", acc0 - a);
    end
    n_chk++;
    if ({nbrk1 - b1, nbrk2 - b2} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL break_others: got %0d %0d pulses, expected 1 1", nbrk1 - b1, nbrk2 - b2);
    end
    a = acc0;
    send_8n1(8'h55);
    idle_bits(3);
    n_chk++;
    if (acc0 - a !== 1 || w0 !== 8'h55) begin
      n_fail++; $display("FAIL break_recover: got %0d words data %h, expected 1 words data 55", acc0 - a, w0);
    end
  endtask

  task automatic test_false_start;
    int a0, a1, a2, b, o;
    a0 = acc0; a1 = acc1; a2 = acc2; b = nbrk0 + nbrk1 + nbrk2; o = novr0;
    @(negedge clk);
    rx = 1'b0;
    repeat (14) @(negedge clk);
    rx = 1'b1;
    idle_bits(3);
    n_chk++;
    if ({acc0 - a0, acc1 - a1, acc2 - a2} !== 96'h0) begin
      n_fail++; $display("FAIL false_start_words: got %0d %0d %0d, expected 0 0 0", acc0 - a0, acc1 - a1, acc2 - a2);
    end
    n_chk++;
    if ((nbrk0 + nbrk1 + nbrk2 - b) !== 0 || novr0 - o !== 0) begin
      n_fail++; $display("FAIL false_start_pulses: got brk %0d ovr %0d, expected 0 0", nbrk0 + nbrk1 + nbrk2 - b, novr0 - o);
    end
  endtask

  task automatic test_reset_midframe;
    int a;
    send_bits({6'h3f, 1'b1, 8'h7E, 1'b0}, 5, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({dv0, pe0, fe0, ov0, bk0, d0} !== 13'h0) begin
      n_fail++; $display("FAIL midframe_reset: got %h, expected 0", {dv0, pe0, fe0, ov0, bk0, d0});
    end
    rst_n = 1'b1;
    a = acc0;
    idle_bits(12);
    n_chk++;
    if (acc0 - a !== 0) begin
      n_fail++; $display("FAIL midframe_abandon: got %0d words, expected 0", acc0 - a);
    end
    send_8n1(8'h7E);
    idle_bits(3);
    n_chk++;
    if (acc0 - a !== 1 || w0 !== 8'h7E || {wpe0, wfe0} !== 2'b00) begin
      n_fail++; $display("FAIL midframe_next: got %0d words data %h flags %b, expected 1 7e 00", acc0 - a, w0, {wpe0, wfe0});
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop_bits();
    test_glitch();
    test_back_to_back();
    test_break();
    test_false_start();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
